invsqrt_arbiter: RTL and testbench

- Shares one fastInvSqrt unit among NUM_REQ Madgwick normalisation stages, nominally accelerometer, magnetometer and quaternion.
- Sits between the normalisation FSMs and the single shared fastInvSqrt instance.
- Grants one requester at a time using round-robin order.
- Holds the grant until that requester has taken its result, so only one transaction is ever outstanding.

---
 rtl/madgwick_arb_pkg.sv | 14 +
 rtl/invsqrt_arbiter_if.sv | 39 +++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/invsqrt_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_invsqrt_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/madgwick_arb_pkg.sv
// Shared types and widths for the Madgwick normalisation arbiter.
package madgwick_arb_pkg;

  localparam int unsigned ACC_MAG_SQR_WIDTH = 32;
  localparam int unsigned ARB_DATA_WIDTH    = ACC_MAG_SQR_WIDTH;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUE  = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_RETURN = 2'd3
  } arb_state_t;

endpackage

// File: rtl/invsqrt_arbiter_if.sv
// Requester-side and fastInvSqrt-side handshakes of the shared inverse-sqrt arbiter.
interface invsqrt_arbiter_if
  import madgwick_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid_in;
  logic [NUM_REQ-1:0]            req_ready_in;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in;
  logic [NUM_REQ-1:0]            req_valid_out;
  logic [NUM_REQ-1:0]            req_ready_out;
  logic [DATA_WIDTH-1:0]         req_data_out;

  logic                          isq_valid_in;
  logic                          isq_ready_in;
  logic [DATA_WIDTH-1:0]         isq_data_in;
  logic                          isq_valid_out;
  logic                          isq_ready_out;
  logic [DATA_WIDTH-1:0]         isq_data_out;

  // Arbiter side
  modport master (
    input  req_valid_in, req_data_in, req_ready_out,
           isq_ready_in, isq_valid_out, isq_data_out,
    output req_ready_in, req_valid_out, req_data_out,
           isq_valid_in, isq_data_in, isq_ready_out
  );

  // Requesters plus fastInvSqrt unit
  modport slave (
    output req_valid_in, req_data_in, req_ready_out,
           isq_ready_in, isq_valid_out, isq_data_out,
    input  req_ready_in, req_valid_out, req_data_out,
           isq_valid_in, isq_data_in, isq_ready_out
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set bit of req scanning from rr_ptr+1 upward, wrapping.
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      // rr_ptr+i never exceeds 2*NUM_REQ-1, so one wrap subtraction is enough
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/invsqrt_arbiter.sv
// Round-robin arbiter sharing one fastInvSqrt unit among NUM_REQ normalisation stages.
// Optional watchdog with arb_timeout port: define INVSQRT_ARB_TIMEOUT_EN.
module invsqrt_arbiter
  import madgwick_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned DATA_WIDTH     = ARB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  invsqrt_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef INVSQRT_ARB_TIMEOUT_EN
  ,
  output logic                       arb_timeout
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("invsqrt_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
  end

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic                  isq_valid_q, isq_valid_d;
  logic                  isq_ready_q, isq_ready_d;
  logic [DATA_WIDTH-1:0] isq_data_q, isq_data_d;
  logic [NUM_REQ-1:0]    req_valid_q, req_valid_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [DATA_WIDTH-1:0] pick_data;
  logic [NUM_REQ-1:0]    grant_oh;

`ifdef INVSQRT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (bus.req_valid_in),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Operand slice of the current winner
  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_data = bus.req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_oh = NUM_REQ'(1) << grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      grant_q     <= '0;
      isq_valid_q <= 1'b0;
      isq_ready_q <= 1'b0;
      isq_data_q  <= '0;
      req_valid_q <= '0;
      req_data_q  <= '0;
`ifdef INVSQRT_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      isq_valid_q <= isq_valid_d;
      isq_ready_q <= isq_ready_d;
      isq_data_q  <= isq_data_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
`ifdef INVSQRT_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    isq_valid_d = isq_valid_q;
    isq_ready_d = isq_ready_q;
    isq_data_d  = isq_data_q;
    req_valid_d = req_valid_q;
    req_data_d  = req_data_q;
`ifdef INVSQRT_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          isq_data_d  = pick_data;
          grant_d     = pick_idx;
          isq_valid_d = 1'b1;
          state_d     = ARB_ISSUE;
`ifdef INVSQRT_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ARB_ISSUE: begin
        if (isq_valid_q && bus.isq_ready_in) begin
          isq_valid_d = 1'b0;
          isq_ready_d = 1'b1;
          state_d     = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (bus.isq_valid_out && isq_ready_q) begin
          req_data_d  = bus.isq_data_out;
          isq_ready_d = 1'b0;
          req_valid_d = grant_oh;
          state_d     = ARB_RETURN;
        end
      end
      ARB_RETURN: begin
        if (bus.req_ready_out[grant_q]) begin
          req_valid_d = '0;
          rr_ptr_d    = grant_q;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

`ifdef INVSQRT_ARB_TIMEOUT_EN
    // A result landing on the last allowed cycle still wins over the watchdog
    if (state_q == ARB_ISSUE || state_q == ARB_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && state_d != ARB_RETURN) begin
        state_d     = ARB_RETURN;
        isq_valid_d = 1'b0;
        isq_ready_d = 1'b0;
        req_data_d  = '0;
        req_valid_d = grant_oh;
        tmo_d       = 1'b1;
      end
    end
    if (state_q == ARB_RETURN && bus.req_ready_out[grant_q]) begin
      tmo_d = 1'b0;
    end
`endif
  end

  assign bus.req_ready_in  = (state_q == ARB_IDLE) ? pick_gnt : '0;
  assign bus.req_valid_out = req_valid_q;
  assign bus.req_data_out  = req_data_q;
  assign bus.isq_valid_in  = isq_valid_q;
  assign bus.isq_data_in   = isq_data_q;
  assign bus.isq_ready_out = isq_ready_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q != ARB_IDLE);
`ifdef INVSQRT_ARB_TIMEOUT_EN
  assign arb_timeout       = tmo_q;
`endif

endmodule

// File: tb/tb_invsqrt_arbiter.sv
// Directed bench for invsqrt_arbiter; the bench itself plays requesters and the fastInvSqrt unit.
module tb_invsqrt_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 32;
`ifdef INVSQRT_ARB_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 64;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant_id;
  logic       busy;
`ifdef INVSQRT_ARB_TIMEOUT_EN
  logic       arb_timeout;
`endif

  int checks = 0;
  int errors = 0;

  invsqrt_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  invsqrt_arbiter #(
    .NUM_REQ        (NR),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef INVSQRT_ARB_TIMEOUT_EN
    ,
    .arb_timeout (arb_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction for requester idx, starting in ARB_IDLE with its valid already driven
  task automatic serve(input int idx, input logic [31:0] opnd, input logic [31:0] res);
    logic [2:0] oh;
    oh = 3'(1) << idx;
    #1;
    chk("serve_req_ready_in", 32'(bus.req_ready_in), 32'(oh));
    tick();
    bus.req_valid_in[idx] = 1'b0;
    chk("serve_grant_id", 32'(grant_id), 32'(idx));
    chk("serve_isq_valid_in", 32'(bus.isq_valid_in), 32'd1);
    chk("serve_isq_data_in", bus.isq_data_in, opnd);
    tick();
    chk("serve_isq_ready_out", 32'(bus.isq_ready_out), 32'd1);
    chk("serve_isq_valid_drop", 32'(bus.isq_valid_in), 32'd0);
    bus.isq_valid_out = 1'b1;
    bus.isq_data_out  = res;
    tick();
    bus.isq_valid_out = 1'b0;
    chk("serve_req_valid_out", 32'(bus.req_valid_out), 32'(oh));
    chk("serve_req_data_out", bus.req_data_out, res);
    bus.req_ready_out = oh;
    tick();
    bus.req_ready_out = '0;
    chk("serve_valid_clear", 32'(bus.req_valid_out), 32'd0);
    chk("serve_busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.req_valid_in  = '0;
    bus.req_data_in   = '0;
    bus.req_ready_out = '0;
    bus.isq_ready_in  = 1'b0;
    bus.isq_valid_out = 1'b0;
    bus.isq_data_out  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_req_ready_in", 32'(bus.req_ready_in), 32'd0);
    chk("rst_req_valid_out", 32'(bus.req_valid_out), 32'd0);
    chk("rst_isq_valid_in", 32'(bus.isq_valid_in), 32'd0);
    chk("rst_isq_ready_out", 32'(bus.isq_ready_out), 32'd0);
    chk("rst_req_data_out", bus.req_data_out, 32'd0);
    chk("rst_isq_data_in", bus.isq_data_in, 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single request, unit latency 5 cycles: 1/sqrt(4.0) = 0.5 in Q16.16
    bus.req_valid_in = 3'b001;
    bus.req_data_in  = {32'h0, 32'h0, 32'h0004_0000};
    bus.isq_ready_in = 1'b1;
    #1;
    chk("single_req_ready_in", 32'(bus.req_ready_in), 32'b001);
    tick();
    bus.req_valid_in = '0;
    chk("single_isq_valid_in", 32'(bus.isq_valid_in), 32'd1);
    chk("single_isq_data_in", bus.isq_data_in, 32'h0004_0000);
    chk("single_ready_low", 32'(bus.req_ready_in), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    chk("single_isq_valid_drop", 32'(bus.isq_valid_in), 32'd0);
    chk("single_isq_ready_out", 32'(bus.isq_ready_out), 32'd1);
    repeat (4) begin
      tick();
      chk("single_wait_no_result", 32'(bus.req_valid_out), 32'd0);
    end
    bus.isq_valid_out = 1'b1;
    bus.isq_data_out  = 32'h0000_8000;
    tick();
    bus.isq_valid_out = 1'b0;
    chk("single_req_valid_out", 32'(bus.req_valid_out), 32'b001);
    chk("single_req_data_out", bus.req_data_out, 32'h0000_8000);
    chk("single_isq_ready_drop", 32'(bus.isq_ready_out), 32'd0);
    bus.req_ready_out = 3'b001;
    tick();
    bus.req_ready_out = '0;
    chk("single_valid_clear", 32'(bus.req_valid_out), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);

    // Contention from a fresh pointer: order 0,1,2 then 0,2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid_in = 3'b111;
    bus.req_data_in  = {32'h0010_0000, 32'h0009_0000, 32'h0001_0000};
    serve(0, 32'h0001_0000, 32'h0001_0000);
    serve(1, 32'h0009_0000, 32'h0000_5555);
    serve(2, 32'h0010_0000, 32'h0000_4000);
    bus.req_valid_in = 3'b101;
    bus.req_data_in  = {32'h0024_0000, 32'h0, 32'h0019_0000};
    serve(0, 32'h0019_0000, 32'h0000_3333);
    serve(2, 32'h0024_0000, 32'h0000_2AAA);

    // Backpressure on both sides for requester 1
    bus.req_valid_in = 3'b010;
    bus.req_data_in  = {32'h0, 32'h0031_0000, 32'h0};
    bus.isq_ready_in = 1'b0;
    #1;
    chk("bp_req_ready_in", 32'(bus.req_ready_in), 32'b010);
    tick();
    bus.req_valid_in = '0;
    repeat (4) begin
      chk("bp_isq_valid_hold", 32'(bus.isq_valid_in), 32'd1);
      chk("bp_isq_data_hold", bus.isq_data_in, 32'h0031_0000);
      tick();
    end
    chk("bp_isq_valid_last", 32'(bus.isq_valid_in), 32'd1);
    chk("bp_no_ready_out_yet", 32'(bus.isq_ready_out), 32'd0);
    bus.isq_ready_in = 1'b1;
    tick();
    chk("bp_isq_valid_drop", 32'(bus.isq_valid_in), 32'd0);
    chk("bp_isq_ready_out", 32'(bus.isq_ready_out), 32'd1);
    bus.isq_valid_out = 1'b1;
    bus.isq_data_out  = 32'h0000_2492;
    tick();
    bus.isq_valid_out = 1'b0;
    repeat (3) begin
      chk("bp_req_valid_hold", 32'(bus.req_valid_out), 32'b010);
      chk("bp_req_data_hold", bus.req_data_out, 32'h0000_2492);
      chk("bp_no_isq_handshake", 32'({bus.isq_valid_in, bus.isq_ready_out}), 32'd0);
      tick();
    end
    chk("bp_req_valid_last", 32'(bus.req_valid_out), 32'b010);
    bus.req_ready_out = 3'b010;
    tick();
    bus.req_ready_out = '0;
    chk("bp_valid_clear", 32'(bus.req_valid_out), 32'd0);
    chk("bp_grant_id", 32'(grant_id), 32'd1);
    chk("bp_idle", 32'(busy), 32'd0);

    // Reset while waiting on the unit
    bus.req_valid_in = 3'b100;
    bus.req_data_in  = {32'h0004_0000, 32'h0, 32'h0};
    #1;
    tick();
    bus.req_valid_in = '0;
    tick();
    chk("mid_in_wait", 32'(bus.isq_ready_out), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_req_valid_out", 32'(bus.req_valid_out), 32'd0);
    chk("mid_isq_valid_in", 32'(bus.isq_valid_in), 32'd0);
    chk("mid_isq_ready_out", 32'(bus.isq_ready_out), 32'd0);
    chk("mid_req_data_out", bus.req_data_out, 32'd0);
    chk("mid_isq_data_in", bus.isq_data_in, 32'd0);
    chk("mid_grant_id", 32'(grant_id), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    bus.req_valid_in = 3'b100;
    bus.req_data_in  = {32'h0040_0000, 32'h0, 32'h0};
    serve(2, 32'h0040_0000, 32'h0000_2000);

    // Spurious unit result while idle
    bus.isq_valid_out = 1'b1;
    bus.isq_data_out  = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("spur_req_valid_out", 32'(bus.req_valid_out), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);
    chk("spur_data_held", bus.req_data_out, 32'h0000_2000);
    bus.isq_valid_out = 1'b0;

`ifdef INVSQRT_ARB_TIMEOUT_EN
    // Unit never answers: watchdog returns zero after TMO cycles
    bus.req_valid_in = 3'b001;
    bus.req_data_in  = {32'h0, 32'h0, 32'h0004_0000};
    #1;
    tick();
    bus.req_valid_in = '0;
    repeat (7) tick();
    chk("tmo_not_yet", 32'(arb_timeout), 32'd0);
    chk("tmo_no_valid_yet", 32'(bus.req_valid_out), 32'd0);
    tick();
    chk("tmo_flag", 32'(arb_timeout), 32'd1);
    chk("tmo_req_valid_out", 32'(bus.req_valid_out), 32'b001);
    chk("tmo_req_data_out", bus.req_data_out, 32'd0);
    chk("tmo_isq_quiet", 32'({bus.isq_valid_in, bus.isq_ready_out}), 32'd0);
    bus.req_ready_out = 3'b001;
    tick();
    bus.req_ready_out = '0;
    chk("tmo_flag_clear", 32'(arb_timeout), 32'd0);
    chk("tmo_idle", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
